// File: rtl/bw_mult_pkg.sv
// Shared helpers for the pipelined Baugh-Wooley multiplier: partial-product row
// generation, constant-correction mask and the split of rows across pipeline stages.
package bw_mult_pkg;

    localparam int MAXW = 32;
    localparam int MAXP = 2 * MAXW;

    // First partial-product row handled by stage s. Rows are spread evenly so no
    // stage is empty and none holds more than ceil(width/stages) rows.
    function automatic int stage_first_row(input int s, input int width, input int stages);
        return (s * width) / stages;
    endfunction

    // Row `row` of the array, already shifted into its product columns.
    function automatic logic [MAXP-1:0] bw_pp_row(
        input logic [MAXW-1:0] x,
        input logic            y_bit,
        input int              row,
        input logic            tc,
        input int              width
    );
        logic [MAXP-1:0] v;
        v = '0;
        for (int j = 0; j < MAXW; j++) begin
            if (j < width) begin
                v[row + j] = (x[j] & y_bit) ^ (tc & ((row == width - 1) != (j == width - 1)));
            end
        end
        return v;
    endfunction

    function automatic logic [MAXP-1:0] bw_const_mask(input logic tc, input int width);
        logic [MAXP-1:0] v;
        v = '0;
        if (tc) begin
            v[width]         = 1'b1;
            v[2 * width - 1] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/bw_csa_row.sv
// One carry-save row: folds a partial-product row into the running sum/carry pair.
module bw_csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_sum,
    input  logic [N-1:0] i_carry,
    input  logic [N-1:0] i_pp,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry
);

    assign o_sum = i_sum ^ i_carry ^ i_pp;

    // Carry out of the top column is discarded: the product is taken modulo 2^N.
    assign o_carry = {(i_sum[N-2:0] & i_carry[N-2:0])
                    | (i_sum[N-2:0] & i_pp[N-2:0])
                    | (i_carry[N-2:0] & i_pp[N-2:0]), 1'b0};

endmodule

// File: rtl/bw_mult_pipe.sv
// Pipelined signed/unsigned Baugh-Wooley multiplier with valid/ready handshake.
// Every stage advances together; bubbles travel as invalid slices so latency is fixed.
module bw_mult_pipe
    import bw_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               tc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               tc_out
);

    localparam int PW = 2 * WIDTH;

    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = stage_first_row(s, WIDTH, STAGES);
        localparam int HI = stage_first_row(s + 1, WIDTH, STAGES);

        logic [PW-1:0]     w_sum_in;
        logic [PW-1:0]     w_carry_in;
        logic [WIDTH-1:0]  w_x;
        logic [WIDTH-1:LO] w_y;
        logic              w_tc;
        logic              w_vld;
        logic [PW-1:0]     w_sum_out;
        logic [PW-1:0]     w_carry_out;

        if (s == 0) begin : g_src
            // Correction constants enter as the initial running sum.
            assign w_sum_in   = PW'(bw_const_mask(tc_in, WIDTH));
            assign w_carry_in = '0;
            assign w_x        = x;
            assign w_y        = y;
            assign w_tc       = tc_in;
            assign w_vld      = in_valid;
        end else begin : g_src
            assign w_sum_in   = g_stg[s-1].g_reg.r_sum;
            assign w_carry_in = g_stg[s-1].g_reg.r_carry;
            assign w_x        = g_stg[s-1].g_reg.r_x;
            assign w_y        = g_stg[s-1].g_reg.r_y;
            assign w_tc       = g_stg[s-1].g_reg.r_tc;
            assign w_vld      = g_stg[s-1].g_reg.r_vld;
        end

        for (genvar r = LO; r < HI; r++) begin : g_row
            logic [PW-1:0] w_sum_i;
            logic [PW-1:0] w_carry_i;
            logic [PW-1:0] w_pp;
            logic [PW-1:0] w_sum_o;
            logic [PW-1:0] w_carry_o;

            if (r == LO) begin : g_first
                assign w_sum_i   = w_sum_in;
                assign w_carry_i = w_carry_in;
            end else begin : g_next
                assign w_sum_i   = g_row[r-1].w_sum_o;
                assign w_carry_i = g_row[r-1].w_carry_o;
            end

            assign w_pp = PW'(bw_pp_row(MAXW'(w_x), w_y[r], r, w_tc, WIDTH));

            bw_csa_row #(
                .N(PW)
            ) u_csa (
                .i_sum   (w_sum_i),
                .i_carry (w_carry_i),
                .i_pp    (w_pp),
                .o_sum   (w_sum_o),
                .o_carry (w_carry_o)
            );
        end

        assign w_sum_out   = g_row[HI-1].w_sum_o;
        assign w_carry_out = g_row[HI-1].w_carry_o;

        if (s < STAGES - 1) begin : g_reg
            logic [PW-1:0]     r_sum;
            logic [PW-1:0]     r_carry;
            logic [WIDTH-1:0]  r_x;
            logic [WIDTH-1:HI] r_y;
            logic              r_tc;
            logic              r_vld;

            // Only the multiplier bits still to be consumed travel onward.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum   <= '0;
                    r_carry <= '0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_tc    <= 1'b0;
                    r_vld   <= 1'b0;
                end else if (w_adv) begin
                    r_sum   <= w_sum_out;
                    r_carry <= w_carry_out;
                    r_x     <= w_x;
                    r_y     <= w_y[WIDTH-1:HI];
                    r_tc    <= w_tc;
                    r_vld   <= w_vld;
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    p         <= '0;
                    tc_out    <= 1'b0;
                end else if (w_adv) begin
                    out_valid <= w_vld;
                    if (w_vld) begin
                        p      <= w_sum_out + w_carry_out;
                        tc_out <= w_tc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bw_mult_pipe.sv
// Bench for bw_mult_pipe: one 8-bit/4-stage instance with directed handshake tests and
// four 4-bit instances (1..4 stages) with an exhaustive randomized-handshake sweep.
module tb_bw_mult_pipe;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Exact product from integer arithmetic, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic tc, input int w);
        longint sa, sb, pr;
        sa = longint'(a);
        sb = longint'(b);
        if (tc) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        pr = sa * sb;
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_h
        localparam int W = (g == 0) ? 8 : 4;
        localparam int S = (g == 0) ? 4 : g;

        logic           rst, in_valid, in_ready, tc_in, out_valid, out_ready, tc_out;
        logic [W-1:0]   x, y;
        logic [2*W-1:0] p;

        logic [63:0] qp[$];
        logic        qt[$];
        int          qd[$];
        int          lin[$];
        logic [63:0] lout_p[$];
        logic        lout_tc[$];
        int          lout_c[$];
        int          n_adv = 0;
        int          cyc = 0;

        bw_mult_pipe #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .x         (x),
            .y         (y),
            .tc_in     (tc_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .p         (p),
            .tc_out    (tc_out)
        );

        // Reference: each accepted op must appear after exactly S advancing edges, in order.
        always @(negedge clk) begin
            cyc++;
            if (rst) begin
                qp.delete(); qt.delete(); qd.delete();
                lin.delete(); lout_p.delete(); lout_tc.delete(); lout_c.delete();
            end else begin
                if (out_valid) begin
                    if (qp.size() == 0) begin
                        chk($sformatf("i%0d_spurious", g), 64'(out_valid), 64'd0);
                    end else begin
                        chk($sformatf("i%0d_p", g), 64'(p), qp[0]);
                        chk($sformatf("i%0d_tc", g), 64'(tc_out), 64'(qt[0]));
                        chk($sformatf("i%0d_latency", g), 64'(n_adv), 64'(qd[0]));
                    end
                end else if (qp.size() > 0 && qd[0] <= n_adv) begin
                    chk($sformatf("i%0d_lost", g), 64'(out_valid), 64'd1);
                end
                if (!out_valid || out_ready) begin
                    if (out_valid && qp.size() > 0) begin
                        lout_p.push_back(qp[0]);
                        lout_tc.push_back(qt[0]);
                        lout_c.push_back(cyc);
                        void'(qp.pop_front()); void'(qt.pop_front()); void'(qd.pop_front());
                    end
                    if (in_valid) begin
                        qp.push_back(ref_mul(32'(x), 32'(y), tc_in, W));
                        qt.push_back(tc_in);
                        qd.push_back(n_adv + S);
                        lin.push_back(cyc);
                    end
                    n_adv++;
                end
            end
        end

        task automatic clear_logs();
            lin.delete(); lout_p.delete(); lout_tc.delete(); lout_c.delete();
        endtask

        task automatic reset_seq();
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            x = '0; y = '0; tc_in = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("i%0d_rst_ov", g), 64'(out_valid), 64'd0);
            chk($sformatf("i%0d_rst_p", g), 64'(p), 64'd0);
            chk($sformatf("i%0d_rst_tc", g), 64'(tc_out), 64'd0);
            rst = 1'b0;
        endtask

        task automatic send(input logic [W-1:0] ix, input logic [W-1:0] iy, input logic itc);
            bit took = 1'b0;
            int k = 0;
            x = ix; y = iy; tc_in = itc; in_valid = 1'b1;
            while (!took && k < 100) begin
                @(negedge clk);
                took = in_ready;
                @(posedge clk);
                #1;
                k++;
            end
            in_valid = 1'b0;
            if (!took) chk($sformatf("i%0d_send_timeout", g), 64'd0, 64'd1);
        endtask

        task automatic drain();
            int k = 0;
            in_valid = 1'b0; out_ready = 1'b1;
            while (qp.size() > 0 && k < 500) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk($sformatf("i%0d_drain", g), 64'(qp.size()), 64'd0);
        endtask

        task automatic run_rand(input int n, input bit exh);
            int acc = 0;
            int k = 0;
            bit took;
            while (acc < n && k < 20000) begin
                if (exh) {tc_in, y, x} = (2*W+1)'(acc);
                else begin
                    x = W'($urandom); y = W'($urandom); tc_in = 1'($urandom);
                end
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 4) != 0;
                @(negedge clk);
                took = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (took) acc++;
                k++;
            end
            chk($sformatf("i%0d_rand_count", g), 64'(acc), 64'(n));
            drain();
        endtask

        if (g == 0) begin : g_dir8
            initial begin
                reset_seq();

                // All-ones operands in both modes.
                clear_logs();
                send(8'hFF, 8'hFF, 1'b0);
                send(8'hFF, 8'hFF, 1'b1);
                drain();
                chk("t3_count", 64'(lout_p.size()), 64'd2);
                chk("t3_p_u", lout_p[0], 64'h0000_FE01);
                chk("t3_tc_u", 64'(lout_tc[0]), 64'd0);
                chk("t3_p_s", lout_p[1], 64'h0000_0001);
                chk("t3_tc_s", 64'(lout_tc[1]), 64'd1);

                // Ten ops with a three-cycle output stall once results start flowing.
                clear_logs();
                fork
                    begin
                        for (int i = 0; i < 10; i++) send(W'($urandom), W'($urandom), 1'($urandom));
                    end
                    begin
                        repeat (4) @(posedge clk);
                        #1;
                        out_ready = 1'b0;
                        repeat (3) begin
                            @(negedge clk);
                            chk("t4_stall_ready", 64'(in_ready), 64'd0);
                            chk("t4_stall_ov", 64'(out_valid), 64'd1);
                        end
                        @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                    end
                join
                drain();
                chk("t4_count", 64'(lout_p.size()), 64'd10);

                // Reset with S-1 ops in flight: nothing may emerge afterwards.
                for (int i = 0; i < S - 1; i++) send(W'($urandom), W'($urandom), 1'($urandom));
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("t5_ov", 64'(out_valid), 64'd0);
                chk("t5_p", 64'(p), 64'd0);
                rst = 1'b0;
                repeat (8) @(posedge clk);
                #1;
                clear_logs();
                send(8'h12, 8'h34, 1'b0);
                drain();
                chk("t5_count", 64'(lout_p.size()), 64'd1);
                chk("t5_lat", 64'(lout_c[0] - lin[0]), 64'(S));
                chk("t5_p_val", lout_p[0], 64'h0000_03A8);

                run_rand(300, 1'b0);
                n_done++;
            end
        end else begin : g_dir4
            initial begin
                reset_seq();

                clear_logs();
                send(4'h8, 4'h8, 1'b1);
                drain();
                chk($sformatf("i%0d_t1_p", g), lout_p[0], 64'h40);
                chk($sformatf("i%0d_t1_lat", g), 64'(lout_c[0] - lin[0]), 64'(S));

                clear_logs();
                send(4'h8, 4'h7, 1'b1);
                send(4'h8, 4'h7, 1'b0);
                drain();
                chk($sformatf("i%0d_t2_count", g), 64'(lout_p.size()), 64'd2);
                chk($sformatf("i%0d_t2_p_s", g), lout_p[0], 64'hC8);
                chk($sformatf("i%0d_t2_p_u", g), lout_p[1], 64'h38);
                chk($sformatf("i%0d_t2_gap", g), 64'(lout_c[1] - lout_c[0]), 64'd1);

                run_rand(512, 1'b1);
                n_done++;
            end
        end
    end

    initial begin
        int t = 0;
        while (n_done < 5 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", 64'(n_done), 64'd5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
